// File: rtl/fifo_nibble_packer_if.sv
// FIFO read port, flush request and packed-word valid/ready output of the nibble packer.
// The master modport is the packer side; slave is the FIFO/downstream side.
interface fifo_nibble_packer_if #(
  parameter int DW      = 4,
  parameter int NIBBLES = 4
);
  localparam int CW = $clog2(NIBBLES) + 1;

  logic                  empty;
  logic [DW-1:0]         rdata;
  logic                  ren;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [DW*NIBBLES-1:0] out_data;
  logic [CW-1:0]         out_cnt;

  modport master (
    input  empty, rdata, flush, out_ready,
    output ren, out_valid, out_data, out_cnt
  );

  modport slave (
    output empty, rdata, flush, out_ready,
    input  ren, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/fifo_nibble_packer.sv
// Drains nibbles from a FIFO read port and packs NIBBLES of them into one word,
// first nibble in the low slot; a flush emits whatever partial word has been captured.
module fifo_nibble_packer #(
  parameter int DW      = 4,
  parameter int NIBBLES = 4
) (
  input logic                  rclk,
  input logic                  rst,
  fifo_nibble_packer_if.master bus
);
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam int WW = DW * NIBBLES;

  typedef enum logic {FILL, OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] captured_q, captured_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          inflight_q, inflight_d;
  logic          flush_pend_q, flush_pend_d;
  logic          out_valid_q, out_valid_d;
  logic [WW-1:0] out_data_q, out_data_d;
  logic          ren;

  always_ff @(posedge rclk) begin
    if (!rst) begin
      state_q      <= FILL;
      issued_q     <= '0;
      captured_q   <= '0;
      out_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      captured_q   <= captured_d;
      out_cnt_q    <= out_cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // out_data_q doubles as the assembly register, so unfilled slots stay zero.
  always_comb begin
    ren          = rst && (state_q == FILL) && !bus.empty &&
                   (issued_q < CW'(NIBBLES)) && !flush_pend_q;
    state_d      = state_q;
    issued_d     = issued_q;
    captured_d   = captured_q;
    out_cnt_d    = out_cnt_q;
    inflight_d   = 1'b0;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    case (state_q)
      FILL: begin
        if (ren) begin
          issued_d = issued_q + CW'(1);
        end
        inflight_d = ren;
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end
        if (inflight_q) begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (captured_q == CW'(i)) begin
              out_data_d[i*DW +: DW] = bus.rdata;
            end
          end
          captured_d = captured_q + CW'(1);
          if (captured_d == CW'(NIBBLES)) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            out_cnt_d   = CW'(NIBBLES);
          end
        end else if (flush_pend_q) begin
          // A flush only resolves once no read is outstanding.
          if (captured_q != '0) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            out_cnt_d   = captured_q;
          end else begin
            flush_pend_d = 1'b0;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d      = FILL;
          out_valid_d  = 1'b0;
          issued_d     = '0;
          captured_d   = '0;
          flush_pend_d = 1'b0;
          out_data_d   = '0;
          out_cnt_d    = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign bus.ren       = ren;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_cnt   = out_cnt_q;
endmodule
